// File: rtl/edge_det_pkg.sv
// rtl/edge_det_pkg.sv - shared mode encoding, counter width and event gating for the edge detector
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int EVT_CNT_W = 8;

  // True when a filtered edge is one the channel's mode wants recorded.
  function automatic logic mode_gate(input edge_mode_e mode, input logic rise, input logic fall);
    return (rise && mode[0]) || (fall && mode[1]);
  endfunction

endpackage

// File: rtl/edge_det_ch.sv
// rtl/edge_det_ch.sv - one channel: sync chain, debounce filter, edge pulses, sticky flag
// EDGE_DET_MC_CNT_EN adds a saturating per-channel event counter.
module edge_det_ch
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              signal_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  edge_mode_e        mode_i,
  input  logic              clr_i,
  output logic              rising_edge_o,
  output logic              falling_edge_o,
  output logic              event_o
`ifdef EDGE_DET_MC_CNT_EN
  ,
  output logic [EVT_CNT_W-1:0] evt_cnt_o
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   stable_q;
  logic [FILT_W-1:0]      cnt_q;
  logic                   accept;
  logic                   evt_set;

  if (SYNC_STAGES == 1) begin : g_sync_one
    always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= signal_i;
    end
  end else begin : g_sync_chain
    always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Counter is bounded by filt_len_i via >=, so lowering the length mid-count accepts at once.
  assign accept  = (s != stable_q) && (cnt_q >= filt_len_i);
  assign evt_set = mode_gate(mode_i, accept & s, accept & ~s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_q       <= 1'b0;
      cnt_q          <= '0;
      rising_edge_o  <= 1'b0;
      falling_edge_o <= 1'b0;
      event_o        <= 1'b0;
    end else begin
      rising_edge_o  <= accept & s;
      falling_edge_o <= accept & ~s;
      if (s == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable_q <= s;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + FILT_W'(1);
      end
      if (evt_set)    event_o <= 1'b1;
      else if (clr_i) event_o <= 1'b0;
    end
  end

`ifdef EDGE_DET_MC_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      evt_cnt_o <= '0;
    end else if (evt_set && (evt_cnt_o != {EVT_CNT_W{1'b1}})) begin
      evt_cnt_o <= evt_cnt_o + EVT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/edge_detector_mc.sv
// rtl/edge_detector_mc.sv - multi-channel debounced edge detector with sticky flags and irq
// EDGE_DET_MC_CNT_EN adds evt_cnt_o, an 8-bit saturating event counter per channel.
module edge_detector_mc
  import edge_det_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     signal_i,
  input  logic [FILT_W-1:0]   filt_len_i,
  input  logic [2*N_CH-1:0]   mode_i,
  input  logic [N_CH-1:0]     clr_i,
  output logic [N_CH-1:0]     rising_edge_o,
  output logic [N_CH-1:0]     falling_edge_o,
  output logic [N_CH-1:0]     event_o,
  output logic                irq_o
`ifdef EDGE_DET_MC_CNT_EN
  ,
  output logic [EVT_CNT_W*N_CH-1:0] evt_cnt_o
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_det_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .signal_i      (signal_i[i]),
      .filt_len_i    (filt_len_i),
      .mode_i        (edge_mode_e'(mode_i[2*i +: 2])),
      .clr_i         (clr_i[i]),
      .rising_edge_o (rising_edge_o[i]),
      .falling_edge_o(falling_edge_o[i]),
      .event_o       (event_o[i])
`ifdef EDGE_DET_MC_CNT_EN
      ,
      .evt_cnt_o     (evt_cnt_o[EVT_CNT_W*i +: EVT_CNT_W])
`endif
    );
  end

  // Flags are already registered, so irq carries no extra latency.
  assign irq_o = |event_o;

endmodule

// File: tb/tb_edge_detector_mc.sv
// tb/tb_edge_detector_mc.sv - self-checking bench for edge_detector_mc (EDGE_DET_MC_CNT_EN optional)
module tb_edge_detector_mc;

  localparam int NC = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] signal_i, filt_len_i, clr_i;
  logic [7:0] mode_i;
  logic [3:0] rising_edge_o, falling_edge_o, event_o;
  logic       irq_o;
`ifdef EDGE_DET_MC_CNT_EN
  logic [31:0] evt_cnt_o;
`endif

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  edge_detector_mc #(.N_CH(NC), .SYNC_STAGES(SS), .FILT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .signal_i      (signal_i),
    .filt_len_i    (filt_len_i),
    .mode_i        (mode_i),
    .clr_i         (clr_i),
    .rising_edge_o (rising_edge_o),
    .falling_edge_o(falling_edge_o),
    .event_o       (event_o),
    .irq_o         (irq_o)
`ifdef EDGE_DET_MC_CNT_EN
    ,
    .evt_cnt_o     (evt_cnt_o)
`endif
  );

  // Reference: input delay line, per-channel debounced level and length of the current mismatch run.
  logic [3:0] dq[$];
  logic [3:0] m_stable, m_rise, m_fall, m_ev;
  int         m_run[NC];
  int         m_cnt[NC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] s;
    if (!rst_n) begin
      dq = {};
      for (int k = 0; k < SS; k++) dq.push_back(4'h0);
      m_stable = '0; m_rise = '0; m_fall = '0; m_ev = '0;
      for (int c = 0; c < NC; c++) begin m_run[c] = 0; m_cnt[c] = 0; end
    end else begin
      s = dq[0];
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < NC; c++) begin
        logic g;
        if (s[c] != m_stable[c]) begin
          m_run[c]++;
          if (m_run[c] > int'(filt_len_i)) begin
            m_stable[c] = s[c];
            m_run[c]    = 0;
            m_rise[c]   = s[c];
            m_fall[c]   = ~s[c];
          end
        end else begin
          m_run[c] = 0;
        end
        g = (m_rise[c] & mode_i[2*c]) | (m_fall[c] & mode_i[2*c+1]);
        if (g)             m_ev[c] = 1'b1;
        else if (clr_i[c]) m_ev[c] = 1'b0;
        if (clr_i[c])              m_cnt[c] = 0;
        else if (g && m_cnt[c] < 255) m_cnt[c]++;
      end
      dq.push_back(signal_i);
      void'(dq.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_rise", rising_edge_o, m_rise);
    chk("model_fall", falling_edge_o, m_fall);
    chk("model_event", event_o, m_ev);
    chk("model_irq", irq_o, |m_ev);
`ifdef EDGE_DET_MC_CNT_EN
    for (int c = 0; c < NC; c++) chk($sformatf("model_cnt%0d", c), evt_cnt_o[8*c +: 8], m_cnt[c]);
`endif
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] sig, filt, clr;
    logic [3:0] er, ef, ev;
    logic       ei;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic r, input logic [3:0] sg, fl, cl, er, ef, ev, input logic ei);
    vec_t v;
    v.rst = r; v.sig = sg; v.filt = fl; v.clr = cl;
    v.er = er; v.ef = ef; v.ev = ev; v.ei = ei;
    tbl.push_back(v);
  endtask

  initial begin
    int nr, nf;
    rst_n = 1'b0; signal_i = 4'hF; filt_len_i = 4'h0; clr_i = 4'h0; mode_i = 8'hFF;

    // Reset with inputs high, release, one-cycle rising burst; then filtered fall/rise on ch0.
    for (int i = 0; i < 3; i++) row(0, 4'hF, 0, 0, 0, 0, 0, 0);
    row(1, 4'hF, 0, 0, 4'h0, 0, 4'h0, 0);
    row(1, 4'hF, 0, 0, 4'h0, 0, 4'h0, 0);
    row(1, 4'hF, 0, 0, 4'hF, 0, 4'hF, 1);
    row(1, 4'hF, 0, 0, 4'h0, 0, 4'hF, 1);
    row(1, 4'hF, 0, 4'hF, 0, 0, 4'h0, 0);
    for (int i = 0; i < 5; i++) row(1, 4'hE, 3, 0, 0, 0, 0, 0);
    row(1, 4'hE, 3, 0, 0, 4'h1, 4'h1, 1);
    row(1, 4'hE, 3, 0, 0, 4'h0, 4'h1, 1);
    for (int i = 0; i < 5; i++) row(1, 4'hF, 3, 0, 0, 0, 4'h1, 1);
    row(1, 4'hF, 3, 0, 4'h1, 0, 4'h1, 1);
    row(1, 4'hF, 3, 0, 4'h0, 0, 4'h1, 1);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst; signal_i = tbl[i].sig; filt_len_i = tbl[i].filt; clr_i = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_rise", i), rising_edge_o, tbl[i].er);
      chk($sformatf("tbl%0d_fall", i), falling_edge_o, tbl[i].ef);
      chk($sformatf("tbl%0d_event", i), event_o, tbl[i].ev);
      chk($sformatf("tbl%0d_irq", i), irq_o, tbl[i].ei);
    end

    // Glitch rejection on ch1 with filt_len=3.
    signal_i = 4'h0; filt_len_i = 0;
    repeat (4) tick();
    clr_i = 4'hF; tick(); clr_i = 4'h0;
    filt_len_i = 3;
    nr = 0; nf = 0;
    signal_i = 4'h2; repeat (3) begin tick(); nr += rising_edge_o[1]; nf += falling_edge_o[1]; end
    signal_i = 4'h0; repeat (10) begin tick(); nr += rising_edge_o[1]; nf += falling_edge_o[1]; end
    chk("glitch3_rise", nr, 0);
    chk("glitch3_fall", nf, 0);
    chk("glitch3_event", event_o[1], 0);
    nr = 0; nf = 0;
    signal_i = 4'h2; repeat (4) begin tick(); nr += rising_edge_o[1]; nf += falling_edge_o[1]; end
    signal_i = 4'h0; repeat (14) begin tick(); nr += rising_edge_o[1]; nf += falling_edge_o[1]; end
    chk("pulse4_rise", nr, 1);
    chk("pulse4_fall", nf, 1);

    // Mode gating: ch2 rise-only, ch3 fall-only.
    filt_len_i = 0; mode_i = 8'h9F;
    clr_i = 4'hF; tick(); clr_i = 4'h0;
    signal_i = 4'hC; repeat (3) tick();
    chk("mode_rise_pulse", rising_edge_o[3:2], 2'b11);
    chk("mode_rise_event", event_o[3:2], 2'b01);
    chk("mode_rise_irq", irq_o, 1);
    signal_i = 4'h0; repeat (3) tick();
    chk("mode_fall_pulse", falling_edge_o[3:2], 2'b11);
    chk("mode_fall_event", event_o[3:2], 2'b11);

    // Clear racing a gated rising pulse on ch0, then clear alone.
    mode_i = 8'hFF;
    clr_i = 4'hF; tick(); clr_i = 4'h0;
    signal_i = 4'h1; repeat (3) tick();
    chk("race_pre_event", event_o[0], 1);
    signal_i = 4'h0; repeat (3) tick();
    signal_i = 4'h1; repeat (2) tick();
    clr_i = 4'h1; tick();
    chk("race_pulse", rising_edge_o[0], 1);
    chk("race_set_wins", event_o[0], 1);
    tick();
    chk("clr_alone_event", event_o[0], 0);
    chk("clr_alone_irq", irq_o, 0);
    clr_i = 4'h0;

`ifdef EDGE_DET_MC_CNT_EN
    clr_i = 4'h1; tick(); clr_i = 4'h0;
    for (int i = 0; i < 260; i++) begin signal_i[0] = ~signal_i[0]; repeat (2) tick(); end
    repeat (3) tick();
    chk("cnt_saturate", evt_cnt_o[7:0], 255);
    clr_i = 4'h1; tick(); clr_i = 4'h0;
    chk("cnt_clear", evt_cnt_o[7:0], 0);
    for (int i = 0; i < 5; i++) begin signal_i[0] = ~signal_i[0]; repeat (2) tick(); end
    repeat (3) tick();
    chk("cnt_five", evt_cnt_o[7:0], 5);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("cnt_reset", evt_cnt_o[7:0], 0);
`endif

    // Randomised run against the reference model.
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < NC; c++) if ($urandom_range(0, 5) == 0) signal_i[c] = ~signal_i[c];
      if (n % 211 == 0) filt_len_i = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      if (n % 97 == 0)  mode_i = 8'($urandom);
      for (int c = 0; c < NC; c++) clr_i[c] = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/edge_detector_mc.md
Name: edge_detector_mc

Overview:
Multi-channel, parametrised successor to the single-bit edge detector.
- Per channel: synchroniser chain, programmable glitch/debounce filter, and registered rising/falling one-cycle pulses.
- Per channel: mode-gated sticky event flags, plus one aggregated interrupt.
- Sits between asynchronous external/GPIO inputs and the control/interrupt logic.

Parameters:
N_CH, 4, number of independent input channels
SYNC_STAGES, 2, synchroniser flops per channel (legal 1..4)
FILT_W, 4, width of the debounce length and per-channel filter counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
signal_i  input  N_CH  raw asynchronous inputs
filt_len_i  input  FILT_W  debounce length, shared by all channels, quasi-static
mode_i  input  2*N_CH  per-channel 2-bit mode, channel i = bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
clr_i  input  N_CH  per-channel sticky-flag clear, level, sampled each clock
rising_edge_o  output  N_CH  one-cycle pulse on filtered 0->1
falling_edge_o  output  N_CH  one-cycle pulse on filtered 1->0
event_o  output  N_CH  sticky flags, mode-gated
irq_o  output  1  OR of event_o

Behaviour:
- Reset (rst_n=0 at a clock edge) clears the following to 0: sync chain, stable value, filter counter, rising_edge_o, falling_edge_o, event_o and irq_o. Reset mid-operation discards any in-progress filter count.
- Sync: signal_i[i] passes through SYNC_STAGES flops; the last stage output is s[i].
- Filter, per channel: stable[i] holds the debounced level and cnt[i] the FILT_W-bit counter.
  - If s==stable: cnt<=0.
  - If s!=stable and cnt>=filt_len_i: stable<=s, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - filt_len_i=0 means no filtering; stable follows s with one flop.
  - A mismatch must persist for filt_len_i+1 consecutive clocks to be accepted.
  - A shorter glitch is rejected and produces no pulse.
  - The counter never wraps: the >= compare guarantees an update before overflow, including when filt_len_i is lowered mid-count.
- Pulses: registered, asserted in the same cycle stable changes, exactly one cycle wide.
  - rising_edge_o=1 iff stable went 0->1 at that edge; falling_edge_o=1 iff it went 1->0.
  - The two are never both 1 on one channel.
  - Pulses are ungated by mode.
- Latency: a signal_i change sampled at clock edge k produces the pulse visible after edge k+SYNC_STAGES+filt_len_i.
- After reset release: an input already high gives a rising pulse after normal latency, because stable resets to 0.
- Sticky: event_o[i] sets on a rising pulse when mode bit0=1, or on a falling pulse when mode bit1=1.
  - clr_i[i]=1 clears it at the next edge.
  - Simultaneous set and clear: set wins.
  - Mode 00 never sets; changing mode does not alter an existing flag.
- irq_o is the combinational OR of the event_o registers, so it has no extra latency.
- Channels are fully independent; simultaneous edges on several channels are all captured.

Optional Feature:
Macro EDGE_DET_MC_CNT_EN.
- Defined:
  - Adds output port evt_cnt_o, width 8*N_CH.
  - Channel i owns bits [8i+7:8i], an 8-bit saturating counter incremented on every mode-gated event (same condition that sets event_o).
  - It holds at 255 once saturated.
  - It clears to 0 on reset or when clr_i[i]=1; clear wins over increment.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package edge_det_pkg holds:
  - mode enum edge_mode_e: EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11.
  - localparam EVT_CNT_W=8.
- Sub-module edge_det_ch: one channel, covering the sync chain, filter, pulse regs, sticky flag and optional counter.
- Top edge_detector_mc instantiates N_CH copies with a generate loop and ORs the flags into irq_o.

Test Plan:
All scenarios use N_CH=4 and SYNC_STAGES=2.
1. Reset: hold rst_n=0 with signal_i=4'hF for 3 clocks -> all outputs 0. Release -> rising_edge_o=4'hF for exactly one cycle, 2 clocks after release with filt_len_i=0.
2. Latency/width: filt_len_i=3, mode=both, raise signal_i[0] and hold -> rising_edge_o[0] pulses once 5 clocks after the first sampling edge and event_o[0]=1. Drop it -> falling_edge_o[0] pulses 5 clocks later.
3. Glitch reject: filt_len_i=3, pulse signal_i[1] high for 3 clocks -> no pulse and event_o[1] stays 0. A 4-clock pulse -> one rising and one falling pulse.
4. Mode gating: mode ch2=01, ch3=10, toggle both inputs high then low -> event_o[2] set only by the rise, event_o[3] only by the fall, raw pulses on both, irq_o=1.
5. Clear race: hold clr_i[0]=1 in the same cycle as a new gated rising pulse -> event_o[0] stays 1. clr_i[0]=1 alone -> event_o[0]=0 next cycle, irq_o drops if no other flag is set.
6. With EDGE_DET_MC_CNT_EN: 260 gated edges on ch0 -> evt_cnt_o[7:0]=255. clr_i[0] -> 0. Reset mid-count -> 0.
